// File: rtl/isp_yuv422.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// isp_yuv422
//
// Purpose:
//   Converts the full-resolution YUV444 stream from the sharpen stage into an
//   interleaved YUV422 stream with one 2*BITS word per pixel. Chroma is shared
//   per horizontal pixel pair: even columns carry U, odd columns carry V.
//   The fixed latency is 3 pixel clocks for data, href and vsync.
//
// Configuration macro:
//   ISP_YUV422_CHROMA_AVG_EN
//     defined   : chroma is pair-averaged with round-half-up.
//     undefined : chroma is decimated (even -> U_even, odd -> V_odd).
//
// Parameters:
//   BITS    component width of Y, U and V
//   WIDTH   nominal active pixels per line (sizes the column counter)
//   HEIGHT  nominal lines per frame (no logic depends on it)
//
// Ports:
//   pclk       pixel clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   in_href    line valid, one pixel per cycle while high
//   in_vsync   frame sync, delayed only
//   in_data_y  luma
//   in_data_u  Cb
//   in_data_v  Cr
//   out_href   in_href delayed 3 cycles
//   out_vsync  in_vsync delayed 3 cycles
//   out_data   {C, Y}; C = U on even columns, V on odd columns; 0 when out_href=0
//   odd_width  sticky: a line of the current frame had an odd pixel count;
//              cleared on in_vsync rising edge (a coincident set wins)
// -----------------------------------------------------------------------------
module isp_yuv422 #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              in_href,
  input  logic              in_vsync,
  input  logic [BITS-1:0]   in_data_y,
  input  logic [BITS-1:0]   in_data_u,
  input  logic [BITS-1:0]   in_data_v,
  output logic              out_href,
  output logic              out_vsync,
  output logic [2*BITS-1:0] out_data,
  output logic              odd_width
);

  localparam int CW = $clog2(WIDTH + 1);

  // Elaboration-time sanity check on the frame geometry.
  if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_geometry
    $error("isp_yuv422: WIDTH and HEIGHT must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // href / vsync delay lines. Tap 0 is the S1 copy, tap 1 is S2, tap 2 drives
  // the outputs.
  // ---------------------------------------------------------------------------
  logic [2:0] href_sr;
  logic [2:0] vsync_sr;
  logic [2:0] href_tap;
  logic [2:0] vsync_tap;

  assign href_tap  = {href_sr[1:0], in_href};
  assign vsync_tap = {vsync_sr[1:0], in_vsync};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync_delay
      always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
          href_sr[gi]  <= 1'b0;
          vsync_sr[gi] <= 1'b0;
        end else begin
          href_sr[gi]  <= href_tap[gi];
          vsync_sr[gi] <= vsync_tap[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pipeline data registers
  // ---------------------------------------------------------------------------
  logic [BITS-1:0]   s1_y_reg, s1_u_reg, s1_v_reg;
  logic [BITS-1:0]   s2_y_reg, s2_u_reg, s2_v_reg;
  logic              s2_odd_reg;
  logic [CW-1:0]     col_reg;
  logic [CW-1:0]     col_next;
  logic              s1_odd;
  logic [2*BITS-1:0] out_data_reg;
  logic [2*BITS-1:0] out_data_next;
  logic              odd_width_reg;
  logic              odd_width_next;

  // col_reg is the column of the pixel currently in S1. It restarts at 0 on
  // the first pixel of every href run, so a mid-line href drop restarts the
  // phase at even.
  always_comb begin
    col_next = '0;
    if (in_href && href_sr[0]) begin
      col_next = col_reg + 1'b1;
    end
  end

  assign s1_odd = href_sr[0] & col_reg[0];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_y_reg   <= '0;
      s1_u_reg   <= '0;
      s1_v_reg   <= '0;
      col_reg    <= '0;
      s2_y_reg   <= '0;
      s2_u_reg   <= '0;
      s2_v_reg   <= '0;
      s2_odd_reg <= 1'b0;
    end else begin
      s1_y_reg   <= in_data_y;
      s1_u_reg   <= in_data_u;
      s1_v_reg   <= in_data_v;
      col_reg    <= col_next;
      s2_y_reg   <= s1_y_reg;
      s2_u_reg   <= s1_u_reg;
      s2_v_reg   <= s1_v_reg;
      s2_odd_reg <= s1_odd;
    end
  end

  // ---------------------------------------------------------------------------
  // Pair classification of the S2 pixel.
  //   s2_even_pair : S2 is even and S1 holds its odd partner. If S1 carries
  //                  href while S2 also does, they belong to the same run and
  //                  S1 is necessarily the next (odd) column.
  //   s2_lone      : S2 is even and the line ended behind it.
  // ---------------------------------------------------------------------------
  logic s2_even_pair;
  logic s2_lone;
  logic vsync_rise;
  logic [BITS-1:0] c_sel;

  assign s2_even_pair = href_sr[1] & ~s2_odd_reg &  href_sr[0];
  assign s2_lone      = href_sr[1] & ~s2_odd_reg & ~href_sr[0];
  assign vsync_rise   = in_vsync & ~vsync_sr[0];

`ifdef ISP_YUV422_CHROMA_AVG_EN
  // Round-half-up average at BITS+1 bits; the shifted result always fits in
  // BITS, so no saturation is needed.
  logic [BITS:0]   u_sum;
  logic [BITS:0]   v_sum;
  logic [BITS-1:0] u_avg;
  logic [BITS-1:0] v_avg;
  logic [BITS-1:0] v_hold_reg;
  logic [BITS-1:0] v_hold_next;

  assign u_sum = {1'b0, s2_u_reg} + {1'b0, s1_u_reg} + {{BITS{1'b0}}, 1'b1};
  assign v_sum = {1'b0, s2_v_reg} + {1'b0, s1_v_reg} + {{BITS{1'b0}}, 1'b1};
  assign u_avg = BITS'(u_sum >> 1);
  assign v_avg = BITS'(v_sum >> 1);

  // The pair's V is computed while the even pixel is output and consumed one
  // cycle later with the odd pixel.
  always_comb begin
    v_hold_next = v_hold_reg;
    if (s2_even_pair) begin
      v_hold_next = v_avg;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      v_hold_reg <= '0;
    end else begin
      v_hold_reg <= v_hold_next;
    end
  end

  always_comb begin
    c_sel = s2_u_reg;
    if (s2_odd_reg) begin
      c_sel = v_hold_reg;
    end else if (s2_even_pair) begin
      c_sel = u_avg;
    end
  end
`else
  // Decimation: each pixel keeps the chroma component of its own phase.
  always_comb begin
    c_sel = s2_u_reg;
    if (s2_odd_reg) begin
      c_sel = s2_v_reg;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output stage (S3)
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data_next = '0;
    if (href_sr[1]) begin
      out_data_next = {c_sel, s2_y_reg};
    end
  end

  // A lone pixel reaching the output on the same edge as a vsync clear keeps
  // the flag set.
  always_comb begin
    odd_width_next = odd_width_reg;
    if (s2_lone) begin
      odd_width_next = 1'b1;
    end else if (vsync_rise) begin
      odd_width_next = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      odd_width_reg <= 1'b0;
    end else begin
      out_data_reg  <= out_data_next;
      odd_width_reg <= odd_width_next;
    end
  end

  assign out_href  = href_sr[2];
  assign out_vsync = vsync_sr[2];
  assign out_data  = out_data_reg;
  assign odd_width = odd_width_reg;

endmodule

// File: tb/tb_isp_yuv422.sv
`timescale 1ns/1ps
// Self-checking bench for isp_yuv422 (BITS=8). Expected chroma follows the
// build: pair-averaged when ISP_YUV422_CHROMA_AVG_EN is defined, decimated
// otherwise.
module tb_isp_yuv422;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_href = 1'b0;
  logic        in_vsync = 1'b0;
  logic [7:0]  in_data_y = '0;
  logic [7:0]  in_data_u = '0;
  logic [7:0]  in_data_v = '0;
  logic        out_href;
  logic        out_vsync;
  logic [15:0] out_data;
  logic        odd_width;

  isp_yuv422 #(.BITS(8), .WIDTH(1280), .HEIGHT(960)) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .in_href   (in_href),
    .in_vsync  (in_vsync),
    .in_data_y (in_data_y),
    .in_data_u (in_data_u),
    .in_data_v (in_data_v),
    .out_href  (out_href),
    .out_vsync (out_vsync),
    .out_data  (out_data),
    .odd_width (odd_width)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic       href;
    logic       vsync;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
    logic [7:0] c_avg;
    logic [7:0] c_dec;
    logic       odd;
  } vec_t;

  typedef struct {
    int          due;
    logic        href;
    logic        vsync;
    logic [15:0] data;
    logic        odd;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[32];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic vec_t mk(input logic h, input logic vs, input logic [7:0] y,
                              input logic [7:0] u, input logic [7:0] v,
                              input logic [7:0] ca, input logic [7:0] cd,
                              input logic odd);
    vec_t r;
    r.href = h; r.vsync = vs; r.y = y; r.u = u; r.v = v;
    r.c_avg = ca; r.c_dec = cd; r.odd = odd;
    return r;
  endfunction

  function automatic logic [7:0] pick_c(input logic [7:0] ca, input logic [7:0] cd);
`ifdef ISP_YUV422_CHROMA_AVG_EN
    return ca;
`else
    return cd;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d (0x%h), expected %0d (0x%h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() != 0) begin
      if (sb[0].due == cyc) begin
        e = sb.pop_front();
        $display("txn cycle %0d: href=%b vsync=%b data=0x%h odd=%b (exp href=%b vsync=%b data=0x%h odd=%b)",
                 cyc, out_href, out_vsync, out_data, odd_width,
                 e.href, e.vsync, e.data, e.odd);
        chk("out_href", {15'b0, out_href}, {15'b0, e.href});
        chk("out_vsync", {15'b0, out_vsync}, {15'b0, e.vsync});
        chk("out_data", out_data, e.data);
        chk("odd_width", {15'b0, odd_width}, {15'b0, e.odd});
      end else if (sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL scoreboard_missed entry due %0d at cycle %0d", e.due, cyc);
      end
    end
  endtask

  // One clock cycle: check whatever is due, then drive the next input set.
  task automatic step(input logic h, input logic vs, input logic [7:0] y,
                      input logic [7:0] u, input logic [7:0] v,
                      input logic push, input logic [7:0] c, input logic odd);
    exp_t e;
    @(negedge pclk);
    check_front();
    @(posedge pclk);
    cyc++;
    #1;
    in_href   = h;
    in_vsync  = vs;
    in_data_y = y;
    in_data_u = u;
    in_data_v = v;
    if (push) begin
      e.due   = cyc + 3;
      e.href  = h;
      e.vsync = vs;
      e.data  = h ? {c, y} : 16'h0000;
      e.odd   = odd;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && sb.size() != 0; k++) begin
      step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             h  vs  y    u    v   c_avg c_dec odd
    tbl[0]  = mk(0, 1,   0,   0,   0,   0,   0, 0);
    tbl[1]  = mk(0, 0,   0,   0,   0,   0,   0, 0);
    tbl[2]  = mk(1, 0,  10, 100,   0, 101, 100, 0);
    tbl[3]  = mk(1, 0,  20, 101, 255, 128, 255, 0);
    tbl[4]  = mk(1, 0,  30, 200,   7, 125, 200, 0);
    tbl[5]  = mk(1, 0,  40,  50,   8,   8,   8, 0);
    tbl[6]  = mk(0, 0,   0,   0,   0,   0,   0, 0);
    tbl[7]  = mk(1, 0,   1,   4,   5,   5,   4, 0);
    tbl[8]  = mk(1, 0,   2,   6,   7,   6,   7, 0);
    tbl[9]  = mk(1, 0,   3,   9,  11,   9,   9, 1);
    tbl[10] = mk(0, 0,   0,   0,   0,   0,   0, 1);
    tbl[11] = mk(1, 0,  50, 255, 255, 255, 255, 1);
    tbl[12] = mk(1, 0,  60, 255, 255, 255, 255, 1);
    tbl[13] = mk(1, 0,  70,   0, 255, 128,   0, 1);
    tbl[14] = mk(1, 0,  80, 255,   0, 128,   0, 1);
    tbl[15] = mk(0, 0,   0,   0,   0,   0,   0, 1);
    tbl[16] = mk(1, 0,  90,   2,   6,   2,   2, 1);
    tbl[17] = mk(0, 0,   0,   0,   0,   0,   0, 1);
    tbl[18] = mk(1, 0,  91,  10,  20,  11,  10, 1);
    tbl[19] = mk(1, 0,  92,  12,  22,  21,  22, 1);
    tbl[20] = mk(0, 0,   0,   0,   0,   0,   0, 1);
    // vsync rising at entry 23 clears the flag from entry 21's output cycle on.
    tbl[21] = mk(0, 0,   0,   0,   0,   0,   0, 0);
    tbl[22] = mk(0, 0,   0,   0,   0,   0,   0, 0);
    tbl[23] = mk(0, 1,   0,   0,   0,   0,   0, 0);
    tbl[24] = mk(0, 0,   0,   0,   0,   0,   0, 0);
    tbl[25] = mk(1, 0,   1,   4,   5,   5,   4, 0);
    tbl[26] = mk(1, 0,   2,   6,   7,   6,   7, 0);
    tbl[27] = mk(1, 0,   3,   9,  11,   9,   9, 1);
    // vsync rising at entry 29 hits the same edge as the lone-pixel set.
    tbl[28] = mk(0, 0,   0,   0,   0,   0,   0, 1);
    tbl[29] = mk(0, 1,   0,   0,   0,   0,   0, 1);
    tbl[30] = mk(0, 0,   0,   0,   0,   0,   0, 1);
    tbl[31] = mk(0, 0,   0,   0,   0,   0,   0, 1);

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_out_href", {15'b0, out_href}, 16'd0);
    chk("reset_out_vsync", {15'b0, out_vsync}, 16'd0);
    chk("reset_out_data", out_data, 16'd0);
    chk("reset_odd_width", {15'b0, odd_width}, 16'd0);
    rst_n = 1'b1;

    // Table-driven main stream
    for (int i = 0; i < 32; i++) begin
      step(tbl[i].href, tbl[i].vsync, tbl[i].y, tbl[i].u, tbl[i].v, 1'b1,
           pick_c(tbl[i].c_avg, tbl[i].c_dec), tbl[i].odd);
    end
    drain();

    // Mid-line reset: start a line, then pull rst_n low for one cycle.
    step(1'b1, 1'b0, 8'd5, 8'd6, 8'd7, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd6, 8'd7, 8'd8, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd7, 8'd8, 8'd9, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd8, 8'd9, 8'd10, 1'b0, 8'd0, 1'b0);
    chk("pre_reset_out_href", {15'b0, out_href}, 16'd1);
    chk("pre_reset_odd_width", {15'b0, odd_width}, 16'd1);
    #1;
    rst_n   = 1'b0;
    in_href = 1'b0;
    #1;
    chk("midreset_out_href", {15'b0, out_href}, 16'd0);
    chk("midreset_out_vsync", {15'b0, out_vsync}, 16'd0);
    chk("midreset_out_data", out_data, 16'd0);
    chk("midreset_odd_width", {15'b0, odd_width}, 16'd0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;

    // Fresh line after reset: first pixel is even, 3-cycle latency, flag clear.
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b0, 8'd11, 8'd30, 8'd50, 1'b1, pick_c(8'd35, 8'd30), 1'b0);
    step(1'b1, 1'b0, 8'd22, 8'd40, 8'd61, 1'b1, pick_c(8'd56, 8'd61), 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
